// File: rtl/hexkeypad_pkg.sv
// hexkeypad_pkg: shared types and constants for the 4x4 hex keypad scanner.
// Used by hexkeypad and hexkeypad_debounce.
package hexkeypad_pkg;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_ONE   = 2'd1,
    RES_MULTI = 2'd2
  } res_kind_t;

  typedef struct packed {
    res_kind_t  kind;
    logic [3:0] code;
  } frame_res_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } key_state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Nibble 4r+c holds the legend of row r, column c (star = E, hash = F).
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] idx;
    idx = {r, c};
    return KEYMAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/hexkeypad_debounce.sv
// hexkeypad_debounce: counts consecutive identical frame results and flags
// the result as stable once DEBOUNCE matching frames have been seen.
module hexkeypad_debounce
  import hexkeypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_valid,
  input  frame_res_t frame_res,
  output logic       stable,
  output frame_res_t stable_res
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0] count;
  frame_res_t    last_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      last_res <= '0;
    end else if (frame_valid) begin
      last_res <= frame_res;
      if (frame_res == last_res) begin
        if (count < CW'(DEBOUNCE))
          count <= count + 1'b1;
      end else begin
        count <= CW'(1);
      end
    end
  end

  assign stable     = (count == CW'(DEBOUNCE));
  assign stable_res = last_res;

endmodule

// File: rtl/hexkeypad.sv
// hexkeypad: 4x4 matrix keypad scanner with per-frame debounce and press FSM.
// Define HEXKEYPAD_WORD_EN to add a 16-bit shift-in word of accepted keys.
module hexkeypad
  import hexkeypad_pkg::*;
#(
  parameter int SCAN_DIV = 4096,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
`ifdef HEXKEYPAD_WORD_EN
  ,
  output logic [15:0] word
`endif
);

  localparam int SW = $clog2(SCAN_DIV);

  logic [3:0]    row_meta, row_sync;
  logic [SW-1:0] slot;
  logic [1:0]    col_idx;
  logic [15:0]   snapshot;
  logic          frame_done;
  logic          slot_end;
  logic [4:0]    zeros;
  logic [3:0]    hit;
  frame_res_t    frame_res;
  logic          stable;
  frame_res_t    stable_res;
  key_state_t    state, state_next;
  logic          load_key, valid_next, held_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign slot_end = (slot == SW'(SCAN_DIV - 1));

  // Rows are sampled in the last slot of each column so the strobe has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= '0;
      col        <= COL_RESET;
      col_idx    <= '0;
      snapshot   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (slot_end) begin
        slot                          <= '0;
        col                           <= {col[2:0], col[3]};
        col_idx                       <= col_idx + 2'd1;
        snapshot[{col_idx, 2'b00} +: 4] <= row_sync;
        frame_done                    <= (col_idx == 2'd3);
      end else begin
        slot <= slot + 1'b1;
      end
    end
  end

  // Snapshot bit 4c+r is row r of column c; MULTI carries code 0 so repeats compare equal.
  always_comb begin
    zeros          = '0;
    hit            = '0;
    frame_res.kind = RES_NONE;
    frame_res.code = '0;
    for (int i = 0; i < 16; i++) begin
      if (!snapshot[i]) begin
        zeros = zeros + 5'd1;
        hit   = 4'(i);
      end
    end
    if (zeros == 5'd1) begin
      frame_res.kind = RES_ONE;
      frame_res.code = key_code(hit[1:0], hit[3:2]);
    end else if (zeros > 5'd1) begin
      frame_res.kind = RES_MULTI;
    end
  end

  hexkeypad_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_valid(frame_done),
    .frame_res  (frame_res),
    .stable     (stable),
    .stable_res (stable_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // A release must be seen before another key is accepted, so roll-over is silent.
  always_comb begin
    state_next = state;
    load_key   = 1'b0;
    valid_next = 1'b0;
    held_next  = key_held;
    case (state)
      IDLE: begin
        if (stable && stable_res.kind == RES_ONE) begin
          state_next = PRESSED;
          load_key   = 1'b1;
          valid_next = 1'b1;
          held_next  = 1'b1;
        end
      end
      PRESSED: begin
        if (stable && stable_res.kind == RES_NONE) begin
          state_next = IDLE;
          held_next  = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key       <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= valid_next;
      key_held  <= held_next;
      if (load_key)
        key <= stable_res.code;
    end
  end

`ifdef HEXKEYPAD_WORD_EN
  // Key D acts as a clear for the assembled word instead of being shifted in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word <= '0;
    else if (load_key) begin
      if (stable_res.code == 4'hD)
        word <= '0;
      else
        word <= {word[11:0], stable_res.code};
    end
  end
`endif

endmodule

// File: tb/tb_hexkeypad.sv
// tb_hexkeypad: directed self-checking bench for hexkeypad with a behavioural
// keypad matrix (SCAN_DIV=4, DEBOUNCE=3, one frame = 16 cycles).
module tb_hexkeypad;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
`ifdef HEXKEYPAD_WORD_EN
  logic [15:0] word;
`endif

  logic [15:0] pressed;
  int          n_cmp;
  int          n_err;
  int          pulse_cnt;
  int          dbl_cnt;
  logic        prev_valid;

  hexkeypad #(
    .SCAN_DIV(4),
    .DEBOUNCE(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
`ifdef HEXKEYPAD_WORD_EN
    ,
    .word     (word)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a pressed key at index 4r+c pulls row r low while column c is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[4*r+c] && !col[c])
          row[r] = 1'b0;
  end

  initial begin
    pulse_cnt  = 0;
    dbl_cnt    = 0;
    prev_valid = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid) begin
      pulse_cnt = pulse_cnt + 1;
      if (prev_valid)
        dbl_cnt = dbl_cnt + 1;
    end
    prev_valid = key_valid;
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input int limit, output bit seen, output int waited);
    int base;
    base   = pulse_cnt;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < limit) begin
      @(negedge clk);
      waited++;
      if (pulse_cnt != base)
        seen = 1'b1;
    end
  endtask

  task automatic wait_held_low(input int limit, output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < limit) begin
      @(negedge clk);
      waited++;
      if (!key_held)
        seen = 1'b1;
    end
  endtask

  task automatic apply_stimulus(input int idx, input logic [3:0] exp_key, input string tag);
    bit seen;
    int waited;
    pressed[idx] = 1'b1;
    wait_pulse(96, seen, waited);
    check_output({tag, "_pulse"}, 16'(seen), 16'd1);
    check_output({tag, "_key"}, 16'(key), 16'(exp_key));
    pressed[idx] = 1'b0;
    wait_held_low(128, seen, waited);
    check_output({tag, "_release"}, 16'(seen), 16'd1);
  endtask

  initial begin
    bit          seen;
    int          waited;
    int          base;
    logic [3:0]  exp_col;
    logic [3:0]  one_hot;

    n_cmp   = 0;
    n_err   = 0;
    pressed = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_col", 16'(col), 16'h000E);
    check_output("rst_key", 16'(key), 16'h0000);
    check_output("rst_valid", 16'(key_valid), 16'h0000);
    check_output("rst_held", 16'(key_held), 16'h0000);
`ifdef HEXKEYPAD_WORD_EN
    check_output("rst_word", word, 16'h0000);
`endif
    rst_n = 1'b1;

    // Column strobe rotation over one frame.
    for (int n = 0; n < 16; n++) begin
      one_hot = 4'b0001 << (n / 4);
      exp_col = ~one_hot;
      check_output($sformatf("col_n%0d", n), 16'(col), 16'(exp_col));
      @(negedge clk);
    end
    repeat (144) @(negedge clk);
    check_output("idle_pulses", 16'(pulse_cnt), 16'd0);
    check_output("idle_key", 16'(key), 16'h0000);
    check_output("idle_held", 16'(key_held), 16'h0000);

    // Key 5 (r1c1) held for 5 frames.
    pressed[5] = 1'b1;
    wait_pulse(80, seen, waited);
    check_output("k5_pulse", 16'(seen), 16'd1);
    check_output("k5_latency", 16'(waited >= 32 && waited <= 80), 16'd1);
    check_output("k5_key", 16'(key), 16'h0005);
    check_output("k5_held", 16'(key_held), 16'd1);
    repeat (80 - waited) @(negedge clk);
    base = pulse_cnt;
    pressed[5] = 1'b0;
    wait_held_low(96, seen, waited);
    check_output("k5_release", 16'(seen), 16'd1);
    check_output("k5_rel_latency", 16'(waited >= 32), 16'd1);
    check_output("k5_key_kept", 16'(key), 16'h0005);
    check_output("k5_single", 16'(pulse_cnt - base), 16'd0);

    // Key E (r3c0) bouncing, then steady.
    base = pulse_cnt;
    for (int t = 0; t < 6; t++) begin
      pressed[12] = ~pressed[12];
      repeat (5) @(negedge clk);
    end
    check_output("bounce_quiet", 16'(pulse_cnt - base), 16'd0);
    pressed[12] = 1'b1;
    wait_pulse(96, seen, waited);
    check_output("kE_pulse", 16'(seen), 16'd1);
    check_output("kE_key", 16'(key), 16'h000E);
    repeat (64) @(negedge clk);
    check_output("kE_single", 16'(pulse_cnt - base), 16'd1);
    pressed[12] = 1'b0;
    wait_held_low(128, seen, waited);
    check_output("kE_release", 16'(seen), 16'd1);

    // Keys 5 and 9 together are ignored.
    base = pulse_cnt;
    pressed[5]  = 1'b1;
    pressed[10] = 1'b1;
    repeat (96) @(negedge clk);
    check_output("multi_pulses", 16'(pulse_cnt - base), 16'd0);
    check_output("multi_held", 16'(key_held), 16'd0);
    check_output("multi_key", 16'(key), 16'h000E);
    pressed[5]  = 1'b0;
    pressed[10] = 1'b0;
    repeat (64) @(negedge clk);

    // Roll-over 2 -> 3 without release.
    pressed[1] = 1'b1;
    wait_pulse(96, seen, waited);
    check_output("k2_pulse", 16'(seen), 16'd1);
    check_output("k2_key", 16'(key), 16'h0002);
    base = pulse_cnt;
    pressed[2] = 1'b1;
    repeat (40) @(negedge clk);
    pressed[1] = 1'b0;
    repeat (96) @(negedge clk);
    check_output("roll_no_event", 16'(pulse_cnt - base), 16'd0);
    check_output("roll_key", 16'(key), 16'h0002);
    check_output("roll_held", 16'(key_held), 16'd1);
    pressed[2] = 1'b0;
    wait_held_low(128, seen, waited);
    check_output("roll_release", 16'(seen), 16'd1);
    apply_stimulus(2, 4'h3, "k3");

    // Reset while 7 (r2c0) is held.
    pressed[8] = 1'b1;
    wait_pulse(96, seen, waited);
    check_output("k7_pulse", 16'(seen), 16'd1);
    check_output("k7_key", 16'(key), 16'h0007);
    repeat (21) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_key", 16'(key), 16'h0000);
    check_output("mid_rst_held", 16'(key_held), 16'd0);
    check_output("mid_rst_valid", 16'(key_valid), 16'd0);
    check_output("mid_rst_col", 16'(col), 16'h000E);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(96, seen, waited);
    check_output("k7_redetect", 16'(seen), 16'd1);
    check_output("k7_re_key", 16'(key), 16'h0007);
    pressed[8] = 1'b0;
    wait_held_low(128, seen, waited);
    check_output("k7_release", 16'(seen), 16'd1);

`ifdef HEXKEYPAD_WORD_EN
    // Word assembly: 7 shifted in after reset, then 1,2,3,A, then D clears.
    apply_stimulus(0, 4'h1, "w1");
    apply_stimulus(1, 4'h2, "w2");
    apply_stimulus(2, 4'h3, "w3");
    apply_stimulus(3, 4'hA, "wA");
    check_output("word_123A", word, 16'h123A);
    apply_stimulus(15, 4'hD, "wD");
    check_output("word_clear", word, 16'h0000);
    check_output("word_keyD", 16'(key), 16'h000D);
`endif

    check_output("no_double_pulse", 16'(dbl_cnt), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
